// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the asynchronous FIFO pointer controllers (write side
// today, read side later).
//
// Contents:
//   PTR_MAX_W   widest pointer the helpers handle
//   fifo_depth  DEPTH = 1 << ADDR_W, usable in localparam expressions
//   bin2gray    binary -> reflected Gray code
//   gray2bin    reflected Gray code -> binary
//
// The conversions work on zero-extended PTR_MAX_W-bit values, so one function
// serves any pointer width: the caller zero-extends its operand with a size
// cast and truncates the result back to its own width. Zero extension is
// harmless in both directions because the extra Gray/binary bits stay 0.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wr_ptr_ctrl_if.sv
// -----------------------------------------------------------------------------
// wr_ptr_ctrl_if
// Producer-side bundle of the write pointer controller.
//
// Signals:
//   w_en         producer write request
//   w_accept     write taken this cycle (RAM write enable)
//   w_addr       RAM write address
//   full         registered full flag
//   almost_full  registered almost-full flag
//   wr_ovf       one-cycle pulse per write attempted while full
//   w_level      registered fill level          (WR_PTR_CTRL_LEVEL_EN only)
//   ovf_sticky   overflow seen since last reset (WR_PTR_CTRL_LEVEL_EN only)
//
// Modports:
//   master  producer view (drives w_en)
//   slave   controller view (drives everything else)
//
// Build option: define WR_PTR_CTRL_LEVEL_EN to add w_level and ovf_sticky.
// -----------------------------------------------------------------------------
interface wr_ptr_ctrl_if #(
  parameter int ADDR_W = 4
);

  logic              w_en;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic              full;
  logic              almost_full;
  logic              wr_ovf;
`ifdef WR_PTR_CTRL_LEVEL_EN
  logic [ADDR_W:0]   w_level;
  logic              ovf_sticky;
`endif

`ifdef WR_PTR_CTRL_LEVEL_EN
  modport master (
    output w_en,
    input  w_accept, w_addr, full, almost_full, wr_ovf, w_level, ovf_sticky
  );

  modport slave (
    input  w_en,
    output w_accept, w_addr, full, almost_full, wr_ovf, w_level, ovf_sticky
  );
`else
  modport master (
    output w_en,
    input  w_accept, w_addr, full, almost_full, wr_ovf
  );

  modport slave (
    input  w_en,
    output w_accept, w_addr, full, almost_full, wr_ovf
  );
`endif

endinterface

// File: rtl/gray_sync.sv
// -----------------------------------------------------------------------------
// gray_sync
// Multi-flop synchroniser for a Gray-coded pointer crossing into the clk
// domain. A plain flop chain: no logic between stages, so only one bit of the
// Gray word can be in transition and the captured value is always either the
// old or the new pointer.
//
// Parameters:
//   WIDTH   pointer width
//   STAGES  number of flops in the chain (2..4)
//
// Ports:
//   clk  destination-domain clock
//   rst  synchronous active-high reset, clears every stage
//   d    pointer from the source domain
//   q    synchronised pointer, STAGES edges behind d
// -----------------------------------------------------------------------------
module gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p [STAGES];

  // chain stage boundary: each flop feeds the next directly
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_p[i] <= '0;
      end
    end else begin
      sync_p[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// wr_ptr_ctrl
// Write-side pointer and flag controller of the asynchronous FIFO. Lives in
// the write clock domain between the producer and the dual-port RAM write
// port, and exports its Gray pointer to the read-side controller.
//
// Parameters:
//   ADDR_W       RAM address width; depth = 2**ADDR_W, pointers ADDR_W+1 bits
//   SYNC_STAGES  flops in the read-pointer synchroniser (2..4)
//   AF_MARGIN    almost_full when free slots <= AF_MARGIN (1..2**ADDR_W-1)
//
// Ports:
//   w_clk       write-domain clock
//   rst         synchronous active-high reset
//   r_ptr_gray  read-domain Gray pointer (asynchronous to w_clk)
//   w_ptr_gray  registered Gray write pointer, to the read domain
//   wif         producer bundle (wr_ptr_ctrl_if.slave): w_en, w_accept,
//               w_addr, full, almost_full, wr_ovf [, w_level, ovf_sticky]
//
// Build option: WR_PTR_CTRL_LEVEL_EN adds the registered fill level w_level
// and the sticky overflow flag ovf_sticky. Without it the level subtractor
// still feeds almost_full and flag timing is identical.
//
// Timing: a write accepted on edge n moves w_addr/w_ptr_gray after edge n;
// full and almost_full are computed from the post-write pointer so they rise
// on the same edge that accepts the filling write. Read-pointer progress is
// seen SYNC_STAGES+1 edges after r_ptr_gray changes, so the flags are always
// pessimistic.
// -----------------------------------------------------------------------------
module wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2
) (
  input  logic            w_clk,
  input  logic            rst,
  input  logic [ADDR_W:0] r_ptr_gray,
  output logic [ADDR_W:0] w_ptr_gray,
  wr_ptr_ctrl_if.slave    wif
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  typedef logic [ADDR_W:0]   ptr_t;
  // one bit wider than a pointer so DEPTH itself is representable
  typedef logic [ADDR_W+1:0] cnt_t;

  ptr_t wbin_p0;
  logic full_p0;
  logic almost_full_p0;
  logic wr_ovf_p0;

  ptr_t rq_gray;
  ptr_t rbin_sync;
  ptr_t wbin_next;
  ptr_t wgray_next;
  ptr_t full_gray;
  ptr_t level_next;
  cnt_t free_next;
  logic accept;
  logic full_next;
  logic almost_full_next;
  logic wr_ovf_next;

  gray_sync #(
    .WIDTH  (ADDR_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (w_clk),
    .rst (rst),
    .d   (r_ptr_gray),
    .q   (rq_gray)
  );

  // The RAM must not see a write in a reset cycle, so rst also gates the
  // write enable even though the pointer update is already blocked by reset.
  assign accept = wif.w_en && !full_p0 && !rst;

  assign wbin_next  = wbin_p0 + ptr_t'(accept);
  assign wgray_next = ptr_t'(bin2gray(PTR_MAX_W'(wbin_next)));
  assign rbin_sync  = ptr_t'(gray2bin(PTR_MAX_W'(rq_gray)));

  // Full when the write pointer is exactly one lap ahead of the synchronised
  // read pointer; in Gray code that is the read pointer with its two top bits
  // inverted.
  assign full_gray = {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]};
  assign full_next = (wgray_next == full_gray);

  // Modular subtraction gives the level directly across pointer wrap.
  assign level_next       = wbin_next - rbin_sync;
  assign free_next        = cnt_t'(DEPTH) - {1'b0, level_next};
  assign almost_full_next = (free_next <= cnt_t'(AF_MARGIN));

  assign wr_ovf_next = wif.w_en && full_p0;

  // pointer/flag register stage
  always_ff @(posedge w_clk) begin
    if (rst) begin
      wbin_p0        <= '0;
      w_ptr_gray     <= '0;
      full_p0        <= 1'b0;
      almost_full_p0 <= 1'b0;
      wr_ovf_p0      <= 1'b0;
    end else begin
      wbin_p0        <= wbin_next;
      w_ptr_gray     <= wgray_next;
      full_p0        <= full_next;
      almost_full_p0 <= almost_full_next;
      wr_ovf_p0      <= wr_ovf_next;
    end
  end

  assign wif.w_accept    = accept;
  assign wif.w_addr      = wbin_p0[ADDR_W-1:0];
  assign wif.full        = full_p0;
  assign wif.almost_full = almost_full_p0;
  assign wif.wr_ovf      = wr_ovf_p0;

`ifdef WR_PTR_CTRL_LEVEL_EN
  ptr_t w_level_p0;
  logic ovf_sticky_p0;

  // level/sticky register stage; the sticky flag rises on the same edge as
  // the first wr_ovf pulse and only reset clears it
  always_ff @(posedge w_clk) begin
    if (rst) begin
      w_level_p0    <= '0;
      ovf_sticky_p0 <= 1'b0;
    end else begin
      w_level_p0    <= level_next;
      ovf_sticky_p0 <= ovf_sticky_p0 || wr_ovf_next;
    end
  end

  assign wif.w_level    = w_level_p0;
  assign wif.ovf_sticky = ovf_sticky_p0;
`endif

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wr_ptr_ctrl
// Two controller instances: A (ADDR_W=4, SYNC_STAGES=2, AF_MARGIN=2) and
// B (ADDR_W=2, SYNC_STAGES=3, AF_MARGIN=1). The reference model tracks
// plain write/read counts: the controller sees the read count as it stood
// SYNC_STAGES edges earlier, level = writes - seen reads, full when the level
// equals the depth. Before every clock edge the stimulus process pushes the
// expected visible state into a per-instance queue; the monitor pops and
// compares just before the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wr_ptr_ctrl;

  localparam int NC   = 2;
  localparam int AW_A = 4;
  localparam int SS_A = 2;
  localparam int AF_A = 2;
  localparam int AW_B = 2;
  localparam int SS_B = 3;
  localparam int AF_B = 1;

  localparam int CFG_AW [NC] = '{AW_A, AW_B};
  localparam int CFG_SS [NC] = '{SS_A, SS_B};
  localparam int CFG_AF [NC] = '{AF_A, AF_B};

  typedef struct {
    int addr;
    int gray;
    bit acc;
    bit full;
    bit af;
    bit ovf;
    int lvl;
    bit sticky;
    bit rs;
  } exp_t;

  logic w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  logic            rst_a;
  logic            rst_b;
  logic [AW_A:0]   r_gray_a;
  logic [AW_B:0]   r_gray_b;
  logic [AW_A:0]   w_gray_a;
  logic [AW_B:0]   w_gray_b;

  wr_ptr_ctrl_if #(.ADDR_W(AW_A)) if_a ();
  wr_ptr_ctrl_if #(.ADDR_W(AW_B)) if_b ();

  wr_ptr_ctrl #(.ADDR_W(AW_A), .SYNC_STAGES(SS_A), .AF_MARGIN(AF_A)) dut_a (
    .w_clk      (w_clk),
    .rst        (rst_a),
    .r_ptr_gray (r_gray_a),
    .w_ptr_gray (w_gray_a),
    .wif        (if_a)
  );

  wr_ptr_ctrl #(.ADDR_W(AW_B), .SYNC_STAGES(SS_B), .AF_MARGIN(AF_B)) dut_b (
    .w_clk      (w_clk),
    .rst        (rst_b),
    .r_ptr_gray (r_gray_b),
    .w_ptr_gray (w_gray_b),
    .wif        (if_b)
  );

  // stimulus controls per instance
  bit rs [NC];
  bit en [NC];
  int rd [NC];
  bit done;

  // reference model state
  int m_wr     [NC];
  bit m_full   [NC];
  bit m_af     [NC];
  bit m_ovf    [NC];
  int m_lvl    [NC];
  bit m_sticky [NC];
  int m_pipe   [NC][4];

  exp_t q_a [$];
  exp_t q_b [$];

  // monitor bookkeeping
  int n_checks;
  int n_fail;
  bit have_prev [NC];
  bit prev_rs   [NC];
  int prev_gray [NC];

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset(input int c);
    m_wr[c]     = 0;
    m_full[c]   = 1'b0;
    m_af[c]     = 1'b0;
    m_ovf[c]    = 1'b0;
    m_lvl[c]    = 0;
    m_sticky[c] = 1'b0;
    for (int i = 0; i < 4; i++) m_pipe[c][i] = 0;
  endtask

  task automatic apply();
    rst_a     = rs[0];
    if_a.w_en = en[0];
    r_gray_a  = (AW_A + 1)'(gray_of(rd[0] % (2 << AW_A)));
    rst_b     = rs[1];
    if_b.w_en = en[1];
    r_gray_b  = (AW_B + 1)'(gray_of(rd[1] % (2 << AW_B)));
  endtask

  // One clock: apply inputs, queue the expected pre-edge view, advance the
  // model through the edge, then wait for the next drive point.
  task automatic step();
    exp_t e;
    int   d;
    int   seen;
    int   wr_n;
    int   lvl;
    apply();
    for (int c = 0; c < NC; c++) begin
      d        = 1 << CFG_AW[c];
      e.addr   = m_wr[c] % d;
      e.gray   = gray_of(m_wr[c] % (2 * d));
      e.acc    = en[c] && !m_full[c] && !rs[c];
      e.full   = m_full[c];
      e.af     = m_af[c];
      e.ovf    = m_ovf[c];
      e.lvl    = m_lvl[c];
      e.sticky = m_sticky[c];
      e.rs     = rs[c];
      if (c == 0) q_a.push_back(e);
      else        q_b.push_back(e);

      if (rs[c]) begin
        model_reset(c);
      end else begin
        seen        = m_pipe[c][CFG_SS[c] - 1];
        wr_n        = m_wr[c] + (e.acc ? 1 : 0);
        lvl         = wr_n - seen;
        m_ovf[c]    = en[c] && m_full[c];
        m_full[c]   = (lvl == d);
        m_af[c]     = (d - lvl) <= CFG_AF[c];
        m_sticky[c] = m_sticky[c] || m_ovf[c];
        m_lvl[c]    = lvl;
        for (int i = 3; i > 0; i--) m_pipe[c][i] = m_pipe[c][i-1];
        m_pipe[c][0] = rd[c];
        m_wr[c]      = wr_n;
      end
    end
    @(negedge w_clk);
    #1;
  endtask

  task automatic run_cfg(input int c);
    int d;
    d = 1 << CFG_AW[c];
    // two reset cycles with a write pending
    rs[c] = 1'b1;
    en[c] = 1'b1;
    rd[c] = 0;
    repeat (2) step();
    // fill from empty, read pointer parked at zero
    rs[c] = 1'b0;
    repeat (d) step();
    // writes refused against a full FIFO
    repeat (3) step();
    // one slot freed by the reader while the producer keeps pushing
    rd[c] = 1;
    repeat (CFG_SS[c] + 3) step();
    // wrap run with the reader trailing two behind
    rs[c] = 1'b1;
    rd[c] = 0;
    step();
    rs[c] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_wr[c] - 2 > rd[c]) rd[c] = m_wr[c] - 2;
      step();
    end
    // random traffic with occasional reset
    for (int i = 0; i < 250; i++) begin
      rs[c] = ($urandom_range(0, 79) == 0);
      en[c] = ($urandom_range(0, 3) != 0);
      if (rs[c]) rd[c] = 0;
      else if (rd[c] < m_wr[c] && $urandom_range(0, 1) == 1) rd[c] = rd[c] + 1;
      step();
    end
    rs[c] = 1'b0;
    en[c] = 1'b0;
    step();
  endtask

  task automatic cmp(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic check_snap(input int c, input exp_t e, input int addr, input int gray,
                            input bit acc, input bit full, input bit af, input bit ovf
`ifdef WR_PTR_CTRL_LEVEL_EN
                            , input int lvl, input bit sticky
`endif
                            );
    string p;
    p = (c == 0) ? "A" : "B";
    cmp({p, ".w_addr"},      addr,      e.addr);
    cmp({p, ".w_ptr_gray"},  gray,      e.gray);
    cmp({p, ".w_accept"},    int'(acc), int'(e.acc));
    cmp({p, ".full"},        int'(full), int'(e.full));
    cmp({p, ".almost_full"}, int'(af),  int'(e.af));
    cmp({p, ".wr_ovf"},      int'(ovf), int'(e.ovf));
`ifdef WR_PTR_CTRL_LEVEL_EN
    cmp({p, ".w_level"},     lvl,       e.lvl);
    cmp({p, ".ovf_sticky"},  int'(sticky), int'(e.sticky));
`endif
    if (have_prev[c] && !prev_rs[c]) begin
      cmp({p, ".gray_bits_changed_le1"}, int'($countones(gray ^ prev_gray[c]) <= 1), 1);
    end
    have_prev[c] = 1'b1;
    prev_rs[c]   = e.rs;
    prev_gray[c] = gray;
  endtask

  // stimulus
  initial begin
    done  = 1'b0;
    rs[0] = 1'b1;
    rs[1] = 1'b1;
    en[0] = 1'b1;
    en[1] = 1'b1;
    rd[0] = 0;
    rd[1] = 0;
    model_reset(0);
    model_reset(1);
    apply();
    @(negedge w_clk);
    #1;
    run_cfg(0);
    run_cfg(1);
    done = 1'b1;
  end

  // monitor
  initial begin
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    forever begin
      @(negedge w_clk);
      #3;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
`ifdef WR_PTR_CTRL_LEVEL_EN
        check_snap(0, e, int'(if_a.w_addr), int'(w_gray_a), if_a.w_accept, if_a.full,
                   if_a.almost_full, if_a.wr_ovf, int'(if_a.w_level), if_a.ovf_sticky);
`else
        check_snap(0, e, int'(if_a.w_addr), int'(w_gray_a), if_a.w_accept, if_a.full,
                   if_a.almost_full, if_a.wr_ovf);
`endif
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
`ifdef WR_PTR_CTRL_LEVEL_EN
        check_snap(1, e, int'(if_b.w_addr), int'(w_gray_b), if_b.w_accept, if_b.full,
                   if_b.almost_full, if_b.wr_ovf, int'(if_b.w_level), if_b.ovf_sticky);
`else
        check_snap(1, e, int'(if_b.w_addr), int'(w_gray_b), if_b.w_accept, if_b.full,
                   if_b.almost_full, if_b.wr_ovf);
`endif
      end
      if (done && q_a.size() == 0 && q_b.size() == 0) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wr_ptr_ctrl.md
Name: wr_ptr_ctrl

Overview:
- Parametrised write-side pointer and flag controller for the asynchronous FIFO.
- Generalises the fixed 5-bit write pointer to ADDR_W, with these additions:
  - binary and Gray pointers
  - internal synchroniser for the read-domain Gray pointer
  - registered full and almost-full flags
  - overflow detection
- Sits in the write clock domain, between the producer and the dual-port RAM write port.
- Exports its Gray pointer to the read-side controller.

Parameters:
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2, flops in the read-pointer synchroniser; legal range 2..4.
- AF_MARGIN, 2, almost_full asserts when free slots <= AF_MARGIN; legal range 1..2**ADDR_W-1.

Ports:
- w_clk  in  1  write-domain clock.
- rst  in  1  synchronous active-high reset.
- w_en  in  1  producer write request.
- r_ptr_gray  in  ADDR_W+1  read-domain Gray pointer (asynchronous to w_clk).
- w_addr  out  ADDR_W  RAM write address (low bits of binary pointer).
- w_ptr_gray  out  ADDR_W+1  registered Gray write pointer, to read domain.
- w_accept  out  1  combinational: w_en && !full; drives the RAM write enable.
- full  out  1  registered full flag.
- almost_full  out  1  registered almost-full flag.
- wr_ovf  out  1  one-cycle pulse: write attempted while full.

Behaviour:
- Reset:
  - Synchronous; active-high rst sampled on the w_clk rising edge.
  - Binary pointer, w_ptr_gray, all synchroniser flops, full, almost_full and wr_ovf are all 0.
  - rst overrides w_en in the same cycle.
  - Reset mid-operation discards all state; no partial write is accepted in the reset cycle.
- Pointer:
  - Binary pointer wbin is ADDR_W+1 bits.
  - wbin_next = wbin + w_accept, modulo 2**(ADDR_W+1); natural wrap, MSB toggles every DEPTH writes.
  - w_ptr_gray <= bin2gray(wbin_next), updated on the same edge as wbin.
  - w_addr = wbin[ADDR_W-1:0].
  - Latency: a write accepted at edge n updates w_addr and w_ptr_gray after edge n.
- Synchroniser:
  - r_ptr_gray passes through a SYNC_STAGES-deep flop chain clocked by w_clk, giving rq_gray.
  - No logic sits between the stages.
- Full:
  - full <= (bin2gray(wbin_next) == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}).
  - full asserts on the same edge that accepts the DEPTH-th outstanding write.
  - After r_ptr_gray advances, full deasserts SYNC_STAGES+1 edges later. This is pessimistic, never optimistic.
- Level and almost_full:
  - level_next = wbin_next - gray2bin(rq_gray), ADDR_W+1 bits, range 0..DEPTH.
  - almost_full <= (DEPTH - level_next) <= AF_MARGIN.
  - almost_full is high whenever full is high.
- Overflow:
  - When w_en && full: no pointer change, and wr_ovf = 1 for exactly that cycle (registered, visible the next cycle).
  - Back-to-back blocked writes give a continuous wr_ovf high.
- Simultaneous read and write at full:
  - The write is refused; the read is seen only after synchronisation.
  - The write then proceeds SYNC_STAGES+1 cycles later.
- No state machine beyond the pointer, flag registers and the sticky/optional logic below.

Optional Feature:
- Macro: WR_PTR_CTRL_LEVEL_EN.
- Defined:
  - Adds output w_level [ADDR_W:0], the registered level_next (same edge as full).
  - Adds sticky output ovf_sticky, set by wr_ovf and cleared only by rst.
- Undefined:
  - Neither port exists.
  - The level subtractor is still used internally for almost_full.
  - Flag timing is unchanged.

Decomposition:
- Package fifo_pkg:
  - bin2gray and gray2bin functions, parametrised by width.
  - Localparam helper for DEPTH = 1 << ADDR_W.
  - Shared by the future read-side controller.
- Sub-module gray_sync:
  - Parameters WIDTH and STAGES.
  - Pure flop chain, reset to 0.
  - Reused by the read-side controller for w_ptr_gray.

Test Plan:
- Reset: rst=1 for 2 cycles with w_en=1 → w_addr=0, w_ptr_gray=0, full=0, almost_full=0, wr_ovf=0. First write is accepted on the first edge after rst falls.
- Fill, ADDR_W=4, r_ptr_gray held 0, w_en=1 for 16 cycles:
  - w_addr steps 0..15.
  - almost_full rises after write 14.
  - full rises on the edge accepting write 16.
  - w_ptr_gray = 5'b11000.
- Overflow: keep w_en=1 for 3 more cycles after full → pointer frozen, wr_ovf high 3 cycles; ovf_sticky stays 1 when WR_PTR_CTRL_LEVEL_EN is defined.
- Drain release: from full, set r_ptr_gray = bin2gray(1) → full falls exactly SYNC_STAGES+1 = 3 edges later; one write is accepted, then full rises again.
- Wrap: run 40 writes with r_ptr_gray tracking 2 behind through the model → wbin wraps 31→0, w_ptr_gray is 1-bit-Hamming between consecutive values, full never asserts.
- Parameter sweep: ADDR_W=2, SYNC_STAGES=3, AF_MARGIN=1 → full after 4 writes, almost_full after 3, and release latency of 4 edges.
